// File: rtl/a1339_multiturn.sv
// a1339_multiturn: per-sensor multiturn position/velocity tracker with Avalon read/preset port (velocity built with A1339_VELOCITY_EN)
module a1339_multiturn #(
  parameter int NUMBER_OF_SENSORS = 1,
  parameter int VEL_WIDTH         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [7:0]         sample_sensor,
  input  logic [11:0]        sample_angle,
  input  logic [8:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic signed [31:0] readdata,
  output logic               waitrequest
);
  localparam int N  = NUMBER_OF_SENSORS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;
  logic [11:0]        last_q [N];
  logic [11:0]        last_d [N];
  logic signed [31:0] pos_q  [N];
  logic signed [31:0] pos_d  [N];
  logic [31:0]        cnt_q  [N];
  logic [31:0]        cnt_d  [N];
  logic [N-1:0]       primed_q, primed_d;
  logic [0:0]         state_q, state_d;
  logic signed [31:0] rd_q, rd_d;
  logic               s_ok, w_ok, r_ok, rd_start;
  logic [IW-1:0]      si, wi, ri;
  logic signed [31:0] d_raw, delta, vel_rd, rv;
`ifdef A1339_VELOCITY_EN
  localparam logic signed [31:0] VMAX = (32'sd1 <<< (VEL_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] VMIN = -VMAX - 32'sd1;
  logic signed [VEL_WIDTH-1:0] vel_q [N];
  logic signed [VEL_WIDTH-1:0] vel_d [N];
  logic signed [31:0]          vsat;
`endif
  assign s_ok     = sample_valid && (32'(sample_sensor) < N);
  assign w_ok     = write && (address[8:7] == 2'd0) && (32'(address[6:0]) < N);
  assign r_ok     = 32'(address[6:0]) < N;
  assign si       = sample_sensor[IW-1:0];
  assign wi       = address[IW-1:0];
  assign ri       = address[IW-1:0];
  assign rd_start = (state_q == IDLE) && read;
  // Shortest-path angle delta folded into -2048..2047
  always_comb begin
    d_raw = $signed({20'b0, sample_angle}) - $signed({20'b0, last_q[si]});
    delta = (d_raw > 32'sd2047) ? d_raw - 32'sd4096 : (d_raw < -32'sd2048) ? d_raw + 32'sd4096 : d_raw;
`ifdef A1339_VELOCITY_EN
    vsat  = (delta > VMAX) ? VMAX : (delta < VMIN) ? VMIN : delta;
    vel_rd = 32'(vel_q[ri]);
`else
    vel_rd = 32'sd0;
`endif
  end
  // Per-sensor next state; a same-cycle preset overrides only the position
  always_comb begin
    pos_d    = pos_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
`ifdef A1339_VELOCITY_EN
    vel_d    = vel_q;
`endif
    if (s_ok) begin
      pos_d[si]    = primed_q[si] ? pos_q[si] + delta : $signed({20'b0, sample_angle});
      last_d[si]   = sample_angle;
      cnt_d[si]    = cnt_q[si] + 32'd1;
      primed_d[si] = 1'b1;
`ifdef A1339_VELOCITY_EN
      vel_d[si]    = primed_q[si] ? vsat[VEL_WIDTH-1:0] : '0;
`endif
    end
    if (w_ok) pos_d[wi] = writedata;
  end
  // Read path: capture in the stalled first cycle, present in the second
  always_comb begin
    rv      = !r_ok ? 32'sd0 :
              (address[8:7] == 2'd0) ? pos_q[ri] :
              (address[8:7] == 2'd1) ? vel_rd :
              (address[8:7] == 2'd2) ? $signed({20'b0, last_q[ri]}) : $signed(cnt_q[ri]);
    state_d = rd_start ? DATA : IDLE;
    rd_d    = rd_start ? rv : rd_q;
  end
  // State registers, all cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        pos_q[i]  <= '0;
        last_q[i] <= '0;
        cnt_q[i]  <= '0;
`ifdef A1339_VELOCITY_EN
        vel_q[i]  <= '0;
`endif
      end
      primed_q <= '0;
      state_q  <= IDLE;
      rd_q     <= '0;
    end else begin
      pos_q    <= pos_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
`ifdef A1339_VELOCITY_EN
      vel_q    <= vel_d;
`endif
      primed_q <= primed_d;
      state_q  <= state_d;
      rd_q     <= rd_d;
    end
  end
  assign readdata    = rd_q;
  assign waitrequest = rd_start && !reset;
endmodule

// File: tb/tb_a1339_multiturn.sv
// tb_a1339_multiturn: directed self-checking bench for a1339_multiturn
module tb_a1339_multiturn;
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic [7:0]         sample_sensor = '0;
  logic [11:0]        sample_angle = '0;
  logic [8:0]         address = '0;
  logic               read = 1'b0;
  logic               write = 1'b0;
  logic [31:0]        writedata = '0;
  logic signed [31:0] readdata;
  logic               waitrequest;
  int checks = 0;
  int errors = 0;
`ifdef A1339_VELOCITY_EN
  localparam int VEL_ON = 1;
`else
  localparam int VEL_ON = 0;
`endif

  a1339_multiturn #(.NUMBER_OF_SENSORS(4), .VEL_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_sensor(sample_sensor),
    .sample_angle(sample_angle), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clock = ~clock;

  task automatic do_read(input logic [1:0] sel, input logic [6:0] s, output logic signed [31:0] d,
                         output logic w1, output logic w0);
    address = {sel, s};
    read = 1'b1;
    #1 w1 = waitrequest;
    @(posedge clock); #1;
    w0 = waitrequest;
    d = readdata;
    read = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic smp(input logic [7:0] s, input logic [11:0] a);
    sample_valid = 1'b1;
    sample_sensor = s;
    sample_angle = a;
    @(posedge clock); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wr(input logic [8:0] ad, input logic [31:0] d);
    write = 1'b1;
    address = ad;
    writedata = d;
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  task automatic test_reset;
    logic signed [31:0] d;
    logic w1, w0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (readdata !== 32'sd0) begin errors++; $display("FAIL reset_readdata got %0d want 0", readdata); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", waitrequest); end
    reset = 1'b0;
    @(posedge clock); #1;
    do_read(2'd3, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd0) begin errors++; $display("FAIL reset_count got %0d want 0", d); end
    checks++; if (w1 !== 1'b1 || w0 !== 1'b0) begin errors++; $display("FAIL read_waitstate got %b%b want 10", w1, w0); end
  endtask

  task automatic test_prime;
    logic signed [31:0] d;
    logic w1, w0;
    smp(8'd0, 12'd100);
    do_read(2'd0, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd100) begin errors++; $display("FAIL prime_pos got %0d want 100", d); end
    do_read(2'd1, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd0) begin errors++; $display("FAIL prime_vel got %0d want 0", d); end
    do_read(2'd2, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd100) begin errors++; $display("FAIL prime_last got %0d want 100", d); end
    do_read(2'd3, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd1) begin errors++; $display("FAIL prime_count got %0d want 1", d); end
  endtask

  task automatic test_forward_wrap;
    logic signed [31:0] d;
    logic w1, w0;
    smp(8'd1, 12'd4090);
    smp(8'd1, 12'd5);
    do_read(2'd0, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd4101) begin errors++; $display("FAIL fwd_pos got %0d want 4101", d); end
    do_read(2'd1, 7'd1, d, w1, w0);
    checks++; if (d !== 32'(VEL_ON * 11)) begin errors++; $display("FAIL fwd_vel got %0d want %0d", d, VEL_ON * 11); end
  endtask

  task automatic test_reverse_wrap;
    logic signed [31:0] d;
    logic w1, w0;
    logic [11:0] steps [4];
    steps[0] = 12'd3069; steps[1] = 12'd2045; steps[2] = 12'd1021; steps[3] = 12'd4093;
    smp(8'd2, 12'd3);
    smp(8'd2, 12'd4093);
    do_read(2'd0, 7'd2, d, w1, w0);
    checks++; if (d !== -32'sd3) begin errors++; $display("FAIL rev_pos got %0d want -3", d); end
    do_read(2'd1, 7'd2, d, w1, w0);
    checks++; if (d !== 32'(VEL_ON * -6)) begin errors++; $display("FAIL rev_vel got %0d want %0d", d, VEL_ON * -6); end
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) smp(8'd2, steps[k]);
    do_read(2'd0, 7'd2, d, w1, w0);
    checks++; if (d !== -32'sd12291) begin errors++; $display("FAIL rev3_pos got %0d want -12291", d); end
    do_read(2'd2, 7'd2, d, w1, w0);
    checks++; if (d !== 32'sd4093) begin errors++; $display("FAIL rev3_last got %0d want 4093", d); end
    do_read(2'd3, 7'd2, d, w1, w0);
    checks++; if (d !== 32'sd14) begin errors++; $display("FAIL rev3_count got %0d want 14", d); end
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] d;
    logic w1, w0;
    smp(8'd3, 12'd0);
    smp(8'd3, 12'd1000);
    smp(8'd3, 12'd2000);
    do_read(2'd0, 7'd3, d, w1, w0);
    checks++; if (d !== 32'sd2000) begin errors++; $display("FAIL b2b_pos got %0d want 2000", d); end
    do_read(2'd3, 7'd3, d, w1, w0);
    checks++; if (d !== 32'sd3) begin errors++; $display("FAIL b2b_count got %0d want 3", d); end
    do_read(2'd1, 7'd3, d, w1, w0);
    checks++; if (d !== 32'(VEL_ON * 1000)) begin errors++; $display("FAIL b2b_vel got %0d want %0d", d, VEL_ON * 1000); end
  endtask

  task automatic test_collision;
    logic signed [31:0] d;
    logic w1, w0;
    smp(8'd0, 12'd40);
    sample_valid = 1'b1; sample_sensor = 8'd0; sample_angle = 12'd50;
    write = 1'b1; address = {2'd0, 7'd0}; writedata = 32'd0;
    @(posedge clock); #1;
    sample_valid = 1'b0; write = 1'b0;
    do_read(2'd0, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd0) begin errors++; $display("FAIL coll_pos got %0d want 0", d); end
    do_read(2'd2, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd50) begin errors++; $display("FAIL coll_last got %0d want 50", d); end
    smp(8'd0, 12'd60);
    do_read(2'd0, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd10) begin errors++; $display("FAIL coll_next_pos got %0d want 10", d); end
    do_read(2'd3, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd4) begin errors++; $display("FAIL coll_count got %0d want 4", d); end
  endtask

  task automatic test_out_of_range;
    logic signed [31:0] d;
    logic w1, w0;
    smp(8'd5, 12'd7);
    do_read(2'd3, 7'd5, d, w1, w0);
    checks++; if (d !== 32'sd0) begin errors++; $display("FAIL oor_read got %0d want 0", d); end
    do_read(2'd3, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd2) begin errors++; $display("FAIL oor_alias_count got %0d want 2", d); end
    wr({2'd1, 7'd0}, 32'd123);
    do_read(2'd0, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd10) begin errors++; $display("FAIL sel1_write got %0d want 10", d); end
    wr({2'd0, 7'd6}, 32'd55);
    do_read(2'd0, 7'd2, d, w1, w0);
    checks++; if (d !== -32'sd12291) begin errors++; $display("FAIL oor_write got %0d want -12291", d); end
  endtask

  task automatic test_preset_and_read_collision;
    logic signed [31:0] d;
    logic w1, w0;
    wr({2'd0, 7'd1}, 32'd1000);
    do_read(2'd0, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd1000) begin errors++; $display("FAIL preset_pos got %0d want 1000", d); end
    do_read(2'd2, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd5) begin errors++; $display("FAIL preset_last got %0d want 5", d); end
    smp(8'd1, 12'd10);
    address = {2'd0, 7'd1}; read = 1'b1;
    sample_valid = 1'b1; sample_sensor = 8'd1; sample_angle = 12'd20;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    d = readdata; w0 = waitrequest;
    read = 1'b0;
    @(posedge clock); #1;
    checks++; if (d !== 32'sd1005 || w0 !== 1'b0) begin errors++; $display("FAIL rdcoll_pre got %0d/%b want 1005/0", d, w0); end
    do_read(2'd0, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd1015) begin errors++; $display("FAIL rdcoll_post got %0d want 1015", d); end
    do_read(2'd3, 7'd1, d, w1, w0);
    checks++; if (d !== 32'sd4) begin errors++; $display("FAIL rdcoll_count got %0d want 4", d); end
  endtask

  task automatic test_reset_mid_read;
    logic signed [31:0] d;
    logic w1, w0;
    address = {2'd3, 7'd0}; read = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL midrd_wait_pre got %b want 1", waitrequest); end
    reset = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b0 || readdata !== 32'sd0) begin errors++; $display("FAIL midrd_reset got %b/%0d want 0/0", waitrequest, readdata); end
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_read(2'd3, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd0) begin errors++; $display("FAIL midrd_count got %0d want 0", d); end
    smp(8'd0, 12'd77);
    do_read(2'd0, 7'd0, d, w1, w0);
    checks++; if (d !== 32'sd77) begin errors++; $display("FAIL reprime_pos got %0d want 77", d); end
  endtask

  initial begin
    test_reset;
    test_prime;
    test_forward_wrap;
    test_reverse_wrap;
    test_back_to_back;
    test_collision;
    test_out_of_range;
    test_preset_and_read_collision;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
